mips_seq_ctrl: RTL and testbench

MIPS_SEQ_CTRL -- requirements
Module: mips_seq_ctrl

---
 rtl/mips_pkg.sv | 39 +++
 rtl/mem_wait_timer.sv | 39 +++
 rtl/mips_seq_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_mips_seq_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS sequencing controller.
//   state_t         : FSM state encodings (code 7 deliberately unused)
//   OP_* / FN_*     : opcode and funct field constants for the legal subset
//   MEM_TIMEOUT_DEF : default bound on cycles spent waiting for mem_ready
//   isLegalOp       : true for opcodes the controller can sequence
package mips_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam int unsigned MEM_TIMEOUT_DEF = 15;

  localparam logic [5:0] OP_RTYPE   = 6'b000000;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;

  function automatic logic isLegalOp(input logic [5:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_RTYPE, OP_ADDI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
      default:                                               legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Bounded wait counter for the memory-access states.
//   clock, reset : clock and asynchronous active-low reset
//   clear        : return the count to zero (takes priority over count)
//   count        : one more cycle spent waiting for memory
//   expired      : this waiting cycle is the MEM_TIMEOUT-th one; the
//                  controller abandons the access instead of waiting again
module mem_wait_timer
  import mips_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int unsigned W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT);
  localparam logic [W-1:0] LAST  = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] waitCnt;

  // expired is flagged combinationally on the cycle whose increment would
  // reach the limit, so the FSM leaves on that same edge.
  assign expired = count && (waitCnt == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      waitCnt <= '0;
    end else if (clear) begin
      waitCnt <= '0;
    end else if (count && (waitCnt != LIMIT)) begin
      waitCnt <= waitCnt + 1'b1;
    end
  end

endmodule

// File: rtl/mips_seq_ctrl.sv
// Multi-cycle MIPS instruction sequencing controller.
//   clock, reset      : clock and asynchronous active-low reset
//   run               : allow sequencing of new instructions
//   opcode, funct     : instruction fields from the instruction register
//   zero              : ALU zero flag (beq resolution)
//   mem_ready         : memory access completes this cycle
//   pc_write, ir_write, mem_read, mem_write, reg_write, branch_taken :
//                       combinational datapath strobes
//   state             : current FSM state code
//   retired           : wrapping count of completed instructions
//   fault             : sticky error flag (illegal opcode, timeout, bad state)
module mips_seq_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        branch_taken,
  output logic [2:0]  state,
  output logic [15:0] retired,
  output logic        fault
);

  state_t      stateQ;
  state_t      nextState;
  state_t      nextInstr;
  logic [15:0] retiredQ;
  logic        faultQ;
  logic        doRetire;
  logic        doFault;

  logic        waitState;
  logic        timerClear;
  logic        timerCount;
  logic        timerExpired;

  logic        isSyscall;
  logic        isMemOp;

  assign isSyscall = (opcode == OP_RTYPE) && (funct == FN_SYSCALL);
  assign isMemOp   = (opcode == OP_LW) || (opcode == OP_SW);

  // The counter only runs while parked in FETCH/MEM without mem_ready; any
  // other state (or a completing access) clears it, which gives a fresh
  // count on every entry into a memory state.
  assign waitState  = (stateQ == ST_FETCH) || (stateQ == ST_MEM);
  assign timerCount = waitState && !mem_ready;
  assign timerClear = !waitState || mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) uWaitTimer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timerClear),
    .count  (timerCount),
    .expired(timerExpired)
  );

  always_comb begin
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    branch_taken = 1'b0;
    doRetire     = 1'b0;
    doFault      = 1'b0;
    nextState    = stateQ;
    nextInstr    = run ? ST_FETCH : ST_IDLE;

    case (stateQ)
      ST_IDLE: begin
        if (run) nextState = ST_FETCH;
      end

      ST_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          nextState = ST_DECODE;
        end else if (timerExpired) begin
          doFault   = 1'b1;
          nextState = ST_HALT;
        end
      end

      ST_DECODE: begin
        if (!isLegalOp(opcode)) begin
          doFault   = 1'b1;
          nextState = ST_HALT;
        end else if (isSyscall) begin
          doRetire  = 1'b1;
          nextState = ST_HALT;
        end else if (opcode == OP_J) begin
          pc_write  = 1'b1;
          doRetire  = 1'b1;
          nextState = nextInstr;
        end else begin
          nextState = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (opcode == OP_BEQ) begin
          branch_taken = zero;
          pc_write     = zero;
          doRetire     = 1'b1;
          nextState    = nextInstr;
        end else if (isMemOp) begin
          nextState = ST_MEM;
        end else begin
          nextState = ST_WB;
        end
      end

      ST_MEM: begin
        // Exactly one of read/write is driven, selected by the store opcode.
        if (opcode == OP_SW) mem_write = 1'b1;
        else                 mem_read  = 1'b1;
        if (mem_ready) begin
          if (opcode == OP_SW) begin
            doRetire  = 1'b1;
            nextState = nextInstr;
          end else begin
            nextState = ST_WB;
          end
        end else if (timerExpired) begin
          doFault   = 1'b1;
          nextState = ST_HALT;
        end
      end

      ST_WB: begin
        reg_write = 1'b1;
        doRetire  = 1'b1;
        nextState = nextInstr;
      end

      ST_HALT: begin
        nextState = ST_HALT;
      end

      // The unused code 7 can only come from an upset; park safely and flag it.
      default: begin
        doFault   = 1'b1;
        nextState = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateQ   <= ST_IDLE;
      retiredQ <= '0;
      faultQ   <= 1'b0;
    end else begin
      stateQ <= nextState;
      if (doRetire) retiredQ <= retiredQ + 1'b1;
      if (doFault)  faultQ   <= 1'b1;
    end
  end

  assign state   = stateQ;
  assign retired = retiredQ;
  assign fault   = faultQ;

endmodule

// File: tb/tb_mips_seq_ctrl.sv
// Self-checking bench for mips_seq_ctrl: each instruction is expanded into
// the per-cycle trace the controller should produce, then replayed.
module tb_mips_seq_ctrl;
  import mips_pkg::*;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;
  // strobe vector order: pc_write, ir_write, mem_read, mem_write, reg_write, branch_taken
  localparam logic [5:0] SB_PC = 6'b100000, SB_IR = 6'b010000, SB_MR = 6'b001000,
                         SB_MW = 6'b000100, SB_RW = 6'b000010, SB_BT = 6'b000001;

  logic        clock = 1'b0;
  logic        reset, run, zero, mem_ready;
  logic [5:0]  opcode, funct;
  logic        pc_write, ir_write, mem_read, mem_write, reg_write, branch_taken;
  logic [2:0]  state;
  logic [15:0] retired;
  logic        fault;

  mips_seq_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .branch_taken(branch_taken), .state(state), .retired(retired), .fault(fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  st;
    logic [5:0]  sb;
    logic        rdy;
    logic        rn;
    logic        zr;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [15:0] ret;
    logic        flt;
  } entry_t;

  entry_t      trace[$];
  logic [15:0] modelRet;
  logic        modelFlt;
  int          nChecks = 0;
  int          nErrors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic push(input logic [2:0] st, input logic [5:0] sb, input logic rdy,
                      input logic rn, input logic [5:0] op, input logic [5:0] fn,
                      input logic zr);
    entry_t e;
    e.st = st; e.sb = sb; e.rdy = rdy; e.rn = rn; e.zr = zr;
    e.op = op; e.fn = fn; e.ret = modelRet; e.flt = modelFlt;
    trace.push_back(e);
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // Expected cycles for one legal, non-halting instruction.
  task automatic addInstr(input logic [5:0] op, input logic [5:0] fn, input int fd,
                          input int md, input logic zr, input logic dropRun);
    logic       rn;
    logic [5:0] memSb;
    rn = !dropRun;
    for (int i = 0; i < fd; i++) push(S_FETCH, SB_MR, 1'b0, 1'b1, op, fn, rb());
    push(S_FETCH, SB_MR | SB_IR | SB_PC, 1'b1, 1'b1, op, fn, rb());
    if (op == OP_J) begin
      push(S_DECODE, SB_PC, rb(), rn, op, fn, rb());
      modelRet = modelRet + 16'd1;
    end else if (op == OP_BEQ) begin
      push(S_DECODE, 6'b0, rb(), rn, op, fn, rb());
      push(S_EXEC, zr ? (SB_PC | SB_BT) : 6'b0, rb(), rn, op, fn, zr);
      modelRet = modelRet + 16'd1;
    end else if (op == OP_LW || op == OP_SW) begin
      memSb = (op == OP_LW) ? SB_MR : SB_MW;
      push(S_DECODE, 6'b0, rb(), rn, op, fn, rb());
      push(S_EXEC, 6'b0, rb(), rn, op, fn, rb());
      for (int i = 0; i < md; i++) push(S_MEM, memSb, 1'b0, rn, op, fn, rb());
      push(S_MEM, memSb, 1'b1, rn, op, fn, rb());
      if (op == OP_LW) push(S_WB, SB_RW, rb(), rn, op, fn, rb());
      modelRet = modelRet + 16'd1;
    end else begin
      push(S_DECODE, 6'b0, rb(), rn, op, fn, rb());
      push(S_EXEC, 6'b0, rb(), rn, op, fn, rb());
      push(S_WB, SB_RW, rb(), rn, op, fn, rb());
      modelRet = modelRet + 16'd1;
    end
    if (dropRun) begin
      push(S_IDLE, 6'b0, rb(), 1'b0, op, fn, rb());
      push(S_IDLE, 6'b0, rb(), 1'b0, op, fn, rb());
      push(S_IDLE, 6'b0, rb(), 1'b1, op, fn, rb());
    end
  endtask

  task automatic runTrace();
    entry_t e;
    while (trace.size() > 0) begin
      e = trace.pop_front();
      @(negedge clock);
      mem_ready = e.rdy; zero = e.zr; run = e.rn; opcode = e.op; funct = e.fn;
      #1;
      chk("state", 32'(state), 32'(e.st));
      chk("strobes", 32'({pc_write, ir_write, mem_read, mem_write, reg_write, branch_taken}), 32'(e.sb));
      chk("retired", 32'(retired), 32'(e.ret));
      chk("fault", 32'(fault), 32'(e.flt));
    end
  endtask

  task automatic doReset();
    run = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    modelRet = '0;
    modelFlt = 1'b0;
  endtask

  task automatic checkHalted(input int n);
    for (int i = 0; i < n; i++) push(S_HALT, 6'b0, rb(), 1'b1, opcode, funct, rb());
  endtask

  logic [5:0] opTab [7];

  initial begin
    opTab = '{OP_RTYPE, OP_ADDI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J};
    reset = 1'b1; run = 1'b0; zero = 1'b0; mem_ready = 1'b0;
    opcode = '0; funct = '0;
    #2 reset = 1'b0;
    #1;
    chk("rstState", 32'(state), 32'(S_IDLE));
    chk("rstStrobes", 32'({pc_write, ir_write, mem_read, mem_write, reg_write, branch_taken}), 32'd0);
    chk("rstRetired", 32'(retired), 32'd0);
    chk("rstFault", 32'(fault), 32'd0);

    // Directed sequences, then randomized instruction mix.
    doReset();
    push(S_IDLE, 6'b0, 1'b0, 1'b1, 6'b0, 6'b0, 1'b0);
    addInstr(OP_RTYPE, 6'b100000, 0, 0, 1'b0, 1'b0);
    addInstr(OP_LW, 6'b0, 0, 3, 1'b0, 1'b0);
    addInstr(OP_SW, 6'b0, 1, 3, 1'b0, 1'b0);
    addInstr(OP_BEQ, 6'b0, 0, 0, 1'b1, 1'b0);
    addInstr(OP_BEQ, 6'b0, 0, 0, 1'b0, 1'b0);
    addInstr(OP_LW, 6'b0, 14, 14, 1'b0, 1'b0);
    addInstr(OP_ADDI, 6'b0, 2, 0, 1'b0, 1'b1);
    addInstr(OP_J, 6'b0, 0, 0, 1'b0, 1'b1);
    for (int n = 0; n < 60; n++) begin
      logic [5:0] op, fn;
      op = opTab[$urandom_range(0, 6)];
      fn = 6'($urandom);
      if (fn == FN_SYSCALL) fn = 6'b100000;
      addInstr(op, fn, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               rb(), ($urandom_range(0, 5) == 0));
    end
    runTrace();

    // Asynchronous reset in the middle of a fetch.
    @(negedge clock);
    mem_ready = 1'b0; run = 1'b1;
    #1;
    chk("preRstState", 32'(state), 32'(S_FETCH));
    chk("preRstRead", 32'(mem_read), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("asyncState", 32'(state), 32'(S_IDLE));
    chk("asyncStrobes", 32'({pc_write, ir_write, mem_read, mem_write, reg_write, branch_taken}), 32'd0);
    chk("asyncRetired", 32'(retired), 32'd0);
    chk("asyncFault", 32'(fault), 32'd0);

    // Fetch timeout.
    doReset();
    push(S_IDLE, 6'b0, 1'b0, 1'b1, OP_RTYPE, 6'b0, 1'b0);
    for (int i = 0; i < 15; i++) push(S_FETCH, SB_MR, 1'b0, 1'b1, OP_RTYPE, 6'b0, rb());
    modelFlt = 1'b1;
    checkHalted(3);
    runTrace();

    // Illegal opcode.
    doReset();
    push(S_IDLE, 6'b0, 1'b0, 1'b1, 6'b111111, 6'b0, 1'b0);
    push(S_FETCH, SB_MR | SB_IR | SB_PC, 1'b1, 1'b1, 6'b111111, 6'b0, 1'b0);
    push(S_DECODE, 6'b0, rb(), 1'b1, 6'b111111, 6'b0, rb());
    modelFlt = 1'b1;
    checkHalted(3);
    runTrace();

    // Syscall halts cleanly and retires.
    doReset();
    push(S_IDLE, 6'b0, 1'b0, 1'b1, OP_RTYPE, FN_SYSCALL, 1'b0);
    push(S_FETCH, SB_MR | SB_IR | SB_PC, 1'b1, 1'b1, OP_RTYPE, FN_SYSCALL, 1'b0);
    push(S_DECODE, 6'b0, rb(), 1'b1, OP_RTYPE, FN_SYSCALL, rb());
    modelRet = modelRet + 16'd1;
    checkHalted(3);
    runTrace();

    // Load that never completes in MEM.
    doReset();
    push(S_IDLE, 6'b0, 1'b0, 1'b1, OP_LW, 6'b0, 1'b0);
    push(S_FETCH, SB_MR | SB_IR | SB_PC, 1'b1, 1'b1, OP_LW, 6'b0, 1'b0);
    push(S_DECODE, 6'b0, rb(), 1'b1, OP_LW, 6'b0, rb());
    push(S_EXEC, 6'b0, rb(), 1'b1, OP_LW, 6'b0, rb());
    for (int i = 0; i < 15; i++) push(S_MEM, SB_MR, 1'b0, 1'b1, OP_LW, 6'b0, rb());
    modelFlt = 1'b1;
    checkHalted(2);
    runTrace();

    // Retired-count wrap after 65535 jumps.
    doReset();
    opcode = OP_J; funct = '0; mem_ready = 1'b1; zero = 1'b0; run = 1'b1;
    repeat (1 + 2 * 65535) @(posedge clock);
    modelRet = 16'hFFFF;
    addInstr(OP_J, 6'b0, 0, 0, 1'b0, 1'b0);
    addInstr(OP_J, 6'b0, 0, 0, 1'b0, 1'b0);
    runTrace();

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
